// File: rtl/mem_stage.sv
// mem_stage: memory-access stage of the five-stage MIPS pipeline plus the
// MEM/WB pipeline register. Word loads/stores go to a data memory that
// answers with a variable-latency ready handshake; the upstream pipeline is
// stalled while an access is outstanding.
module mem_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        iValid,
    input  logic [31:0] iResult,
    input  logic [31:0] iControlSignal,
    input  logic [31:0] iWriteData,
    input  logic [4:0]  iRegAddress,
    input  logic [31:0] iPC_plus_4,
    input  logic        iMemReady,
    input  logic [31:0] iMemRData,
    output logic        oMemReq,
    output logic        oMemWe,
    output logic [31:0] oMemAddr,
    output logic [31:0] oMemWData,
    output logic        oStall,
    output logic        oAlignErr,
    output logic [31:0] oResult,
    output logic [31:0] oControlSignal,
    output logic [31:0] oReadData,
    output logic [31:0] oPC_plus_4,
    output logic [4:0]  oRegAddress
);

    typedef enum logic {
        STATE_IDLE = 1'b0,
        STATE_WAIT = 1'b1
    } stateT;

    stateT state;
    stateT nextState;

    logic memRead;
    logic memWrite;
    logic memOp;
    logic aligned;
    logic isLoad;

    // Decode of the EX/MEM control word. A store wins if both memory bits
    // are set, so such an instruction is never treated as a load.
    assign memRead  = iControlSignal[10];
    assign memWrite = iControlSignal[11];
    assign memOp    = iValid & (memRead | memWrite);
    assign aligned  = (iResult[1:0] == 2'b00);
    assign isLoad   = memRead & ~memWrite;

    // Memory port is driven straight from EX/MEM; upstream is frozen during
    // an access so these stay constant until the memory answers.
    assign oMemWe    = memWrite;
    assign oMemAddr  = {iResult[31:2], 2'b00};
    assign oMemWData = iWriteData;
    assign oStall    = oMemReq & ~iMemReady;

    // Access-state register; reset abandons any outstanding access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= STATE_IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state and request logic: request in IDLE for an aligned access,
    // and keep requesting in WAIT until the memory signals ready.
    always_comb begin
        nextState = state;
        oMemReq   = 1'b0;
        case (state)
            STATE_IDLE: begin
                if (memOp && aligned) begin
                    oMemReq = 1'b1;
                    if (!iMemReady) begin
                        nextState = STATE_WAIT;
                    end
                end
            end
            STATE_WAIT: begin
                oMemReq = 1'b1;
                if (iMemReady) begin
                    nextState = STATE_IDLE;
                end
            end
            default: begin
                nextState = STATE_IDLE;
            end
        endcase
    end

    // MEM/WB register: bubbles on stall or invalid input, misaligned
    // accesses retire with RegWrite cleared and flag an alignment error.
    always_ff @(posedge clk) begin
        if (reset || oStall || !iValid) begin
            oResult        <= 32'h0;
            oControlSignal <= 32'h0;
            oReadData      <= 32'h0;
            oPC_plus_4     <= 32'h0;
            oRegAddress    <= 5'h0;
            oAlignErr      <= 1'b0;
        end else if (memOp && !aligned) begin
            oResult        <= iResult;
            oControlSignal <= {iControlSignal[31:9], 1'b0, iControlSignal[7:0]};
            oReadData      <= 32'h0;
            oPC_plus_4     <= iPC_plus_4;
            oRegAddress    <= iRegAddress;
            oAlignErr      <= 1'b1;
        end else begin
            oResult        <= iResult;
            oControlSignal <= iControlSignal;
            oReadData      <= isLoad ? iMemRData : 32'h0;
            oPC_plus_4     <= iPC_plus_4;
            oRegAddress    <= iRegAddress;
            oAlignErr      <= 1'b0;
        end
    end

endmodule
